// File: rtl/pulse_train_generator.sv
// Burst pulse generator: emits count pulses (or runs continuously when count is 0)
// of HIGH_CYCLES high followed by LOW_CYCLES low, with abort and a completion strobe.
module pulse_train_generator #(
  parameter int HIGH_CYCLES = 1,
  parameter int LOW_CYCLES  = 3,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   pulse_out,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  localparam int MAX_PH = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int PW     = $clog2(MAX_PH + 1);

  localparam logic [PW-1:0]          HIGH_LD = PW'(HIGH_CYCLES);
  localparam logic [PW-1:0]          LOW_LD  = PW'(LOW_CYCLES);
  localparam logic [PW-1:0]          PH_ONE  = PW'(1);
  localparam logic [COUNT_WIDTH-1:0] REM_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ph_q, ph_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic                   cont_q, cont_d;
  logic                   pulse_q, pulse_d;
  logic                   done_q, done_d;

  // The phase counter holds the cycles left in the current phase; a value of 1
  // marks the last cycle of that phase.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    rem_d   = rem_q;
    cont_d  = cont_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_HIGH;
          ph_d    = HIGH_LD;
          rem_d   = count;
          cont_d  = (count == '0);
        end
      end
      ST_HIGH: begin
        if (stop) begin
          state_d = ST_IDLE;
          ph_d    = '0;
        end else if (ph_q == PH_ONE) begin
          state_d = ST_LOW;
          ph_d    = LOW_LD;
          if (rem_q != '0) rem_d = rem_q - REM_ONE;
        end else begin
          ph_d = ph_q - PH_ONE;
        end
      end
      ST_LOW: begin
        if (stop) begin
          state_d = ST_IDLE;
          ph_d    = '0;
        end else if (ph_q == PH_ONE) begin
          if (rem_q != '0 || cont_q) begin
            state_d = ST_HIGH;
            ph_d    = HIGH_LD;
          end else begin
            state_d = ST_IDLE;
            ph_d    = '0;
          end
        end else begin
          ph_d = ph_q - PH_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_d    = '0;
      end
    endcase
    pulse_d = (state_d == ST_HIGH);
    done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      rem_q   <= '0;
      cont_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: default instance (HIGH=1, LOW=3)
// plus a HIGH=4 instance for mid-HIGH abort.
module tb_pulse_train_generator;

  logic       clock;
  logic       resetn;
  logic       start, stop;
  logic [7:0] count;
  logic       pulse_out, busy, done;
  logic [1:0] dbg_state;

  logic       start2, stop2;
  logic [7:0] count2;
  logic       pulse_out2, busy2, done2;
  logic [1:0] dbg_state2;

  int tests;
  int fails;

  pulse_train_generator #(.HIGH_CYCLES(1), .LOW_CYCLES(3), .COUNT_WIDTH(8)) u_dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .count(count),
    .pulse_out(pulse_out), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  pulse_train_generator #(.HIGH_CYCLES(4), .LOW_CYCLES(3), .COUNT_WIDTH(8)) u_dut4 (
    .clock(clock), .resetn(resetn), .start(start2), .stop(stop2), .count(count2),
    .pulse_out(pulse_out2), .busy(busy2), .done(done2), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Each step lands 1 time unit after a rising edge: inputs set here are sampled at
  // the next edge, outputs read here belong to the cycle just begun.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; stop = 1'b0; count = '0;
    start2 = 1'b0; stop2 = 1'b0; count2 = '0;
    step(); step();
    tests++;
    if ({pulse_out, busy, done, dbg_state} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got p=%b b=%b d=%b s=%0d, want all 0", pulse_out, busy, done, dbg_state);
    end
    tests++;
    if ({pulse_out2, busy2, done2} !== 3'b0) begin
      fails++;
      $display("FAIL reset_outputs4: got p=%b b=%b d=%b, want 0", pulse_out2, busy2, done2);
    end
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if ({pulse_out, busy, done} !== 3'b0) begin
        fails++;
        $display("FAIL post_reset_idle: cycle %0d got p=%b b=%b d=%b, want 0", k, pulse_out, busy, done);
      end
    end
  endtask

  task automatic test_two_pulse();
    count = 8'd2; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      start = 1'b0; count = 8'hAA;
      tests++;
      if (pulse_out !== (k == 1 || k == 5) || busy !== (k >= 1 && k <= 8) || done !== (k == 9)) begin
        fails++;
        $display("FAIL two_pulse: cycle %0d got p=%b b=%b d=%b, want p=%b b=%b d=%b", k, pulse_out, busy, done,
                 (k == 1 || k == 5), (k >= 1 && k <= 8), (k == 9));
      end
    end
  endtask

  task automatic test_continuous();
    count = 8'd0; start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      start = 1'b0;
      tests++;
      if (pulse_out !== (k <= 20 && (k % 4) == 1) || busy !== (k <= 20) || done !== (k == 21)) begin
        fails++;
        $display("FAIL continuous: cycle %0d got p=%b b=%b d=%b, want p=%b b=%b d=%b", k, pulse_out, busy, done,
                 (k <= 20 && (k % 4) == 1), (k <= 20), (k == 21));
      end
      stop = (k == 20);
    end
    stop = 1'b0;
  endtask

  task automatic test_stop_high();
    count2 = 8'd3; start2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      start2 = 1'b0;
      tests++;
      if (pulse_out2 !== (k <= 2) || busy2 !== (k <= 2) || done2 !== (k == 3)) begin
        fails++;
        $display("FAIL stop_high: cycle %0d got p=%b b=%b d=%b, want p=%b b=%b d=%b", k, pulse_out2, busy2, done2,
                 (k <= 2), (k <= 2), (k == 3));
      end
      stop2 = (k == 2);
    end
    stop2 = 1'b0;
  endtask

  task automatic test_start_busy();
    count = 8'd2; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      start = (k == 3 || k == 6);
      count = (k == 3) ? 8'd5 : 8'd7;
      tests++;
      if (pulse_out !== (k == 1 || k == 5) || busy !== (k >= 1 && k <= 8) || done !== (k == 9)) begin
        fails++;
        $display("FAIL start_busy: cycle %0d got p=%b b=%b d=%b, want p=%b b=%b d=%b", k, pulse_out, busy, done,
                 (k == 1 || k == 5), (k >= 1 && k <= 8), (k == 9));
      end
    end
    start = 1'b1; stop = 1'b1; count = 8'd1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if ({pulse_out, busy, done} !== 3'b0) begin
        fails++;
        $display("FAIL start_and_stop: cycle %0d got p=%b b=%b d=%b, want 0", k, pulse_out, busy, done);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    count = 8'd1; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests++;
      if (pulse_out !== (k == 1 || k == 6) || busy !== ((k >= 1 && k <= 4) || (k >= 6 && k <= 9)) ||
          done !== (k == 5 || k == 10)) begin
        fails++;
        $display("FAIL back_to_back: cycle %0d got p=%b b=%b d=%b, want p=%b b=%b d=%b", k, pulse_out, busy, done,
                 (k == 1 || k == 6), ((k >= 1 && k <= 4) || (k >= 6 && k <= 9)), (k == 5 || k == 10));
      end
      start = (k == 5);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_low();
    count = 8'd3; start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      start = 1'b0;
    end
    tests++;
    if (busy !== 1'b1 || pulse_out !== 1'b0) begin
      fails++;
      $display("FAIL mid_low_precheck: got p=%b b=%b, want p=0 b=1", pulse_out, busy);
    end
    #2 resetn = 1'b0;
    #1;
    tests++;
    if ({pulse_out, busy, done} !== 3'b0) begin
      fails++;
      $display("FAIL reset_async: got p=%b b=%b d=%b, want 0", pulse_out, busy, done);
    end
    step();
    resetn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests++;
      if ({pulse_out, busy, done} !== 3'b0) begin
        fails++;
        $display("FAIL reset_quiet: cycle %0d got p=%b b=%b d=%b, want 0", k, pulse_out, busy, done);
      end
    end
    count = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (pulse_out !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_after_reset: got p=%b b=%b, want p=1 b=1", pulse_out, busy);
    end
    for (int k = 0; k < 6; k++) step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_two_pulse();
    step();
    test_continuous();
    step();
    test_stop_high();
    test_start_busy();
    test_back_to_back();
    step();
    test_reset_mid_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
